// File: rtl/sine_lut_unit_if.sv
// Sinus request/response and fp-unit request bundle seen by sine_lut_unit.
// slave = responder view (sine_lut_unit), master = effect/fp-unit side.
interface sine_lut_unit_if;
  logic        sinus_clk_en;
  logic [31:0] sinus_angle;
  logic        sinus_done;
  logic [31:0] sinus_result;
  logic        sin_error;
  logic [31:0] fp_dataa;
  logic [31:0] fp_datab;
  logic [2:0]  fp_operation;
  logic        fp_clk_en;
  logic        fp_done;
  logic [31:0] fp_result;

  modport slave (
    input  sinus_clk_en, sinus_angle, fp_done, fp_result,
    output sinus_done, sinus_result, sin_error,
           fp_dataa, fp_datab, fp_operation, fp_clk_en
  );

  modport master (
    output sinus_clk_en, sinus_angle, fp_done, fp_result,
    input  sinus_done, sinus_result, sin_error,
           fp_dataa, fp_datab, fp_operation, fp_clk_en
  );
endinterface

// File: rtl/sine_lut_unit.sv
// sin(angle) via fp-unit scale/fixsi then quarter-wave ROM; optional SINE_ROUND_EN adds a +0.5 fadds.
// Latency: sum of fp latencies + 4 cycles; requester holds sinus_clk_en until the one-cycle sinus_done.
module sine_lut_unit #(
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int FP_TIMEOUT     = 64
) (
  input logic clk,
  input logic rst,
  sine_lut_unit_if.slave bus
);

  localparam int A       = LUT_ADDR_WIDTH;
  localparam int QUARTER = 1 << A;
  localparam int CNT_W   = $clog2(FP_TIMEOUT + 1);

  localparam logic [31:0] K_SCALE  = 32'h3F22F983 + (32'(A) << 23);
  localparam logic [31:0] F_HALF   = 32'h3F000000;
  localparam logic [31:0] F_ONE    = 32'h3F800000;
  localparam logic [31:0] F_NONE   = 32'hBF800000;
  localparam logic [2:0]  OP_FADDS = 3'd1;
  localparam logic [2:0]  OP_FMULS = 3'd3;
  localparam logic [2:0]  OP_FIXSI = 3'd4;
  localparam real         PI       = 3.14159265358979323846;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALE,
`ifdef SINE_ROUND_EN
    S_ROUND,
`endif
    S_TO_INT,
    S_LOOKUP,
    S_DONE
  } state_t;

  function automatic real sin_taylor(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int k = 1; k < 16; k++) begin
      term = -term * x * x / $itor((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Round-to-nearest-even conversion of a value in [0,1) to IEEE single.
  function automatic logic [31:0] real_to_single(input real v);
    real m;
    real scaled;
    real rem;
    int  e;
    int  r;
    if (v <= 0.0) return 32'h0;
    m = v;
    e = 0;
    for (int k = 0; k < 64; k++) begin
      if (m < 1.0) begin
        m = m * 2.0;
        e = e - 1;
      end
    end
    scaled = (m - 1.0) * 8388608.0;
    r      = $rtoi(scaled);
    rem    = scaled - $itor(r);
    if (rem > 0.5 || (rem == 0.5 && r[0])) r = r + 1;
    if (r >= 8388608) begin
      r = 0;
      e = e + 1;
    end
    return {1'b0, 8'(e + 127), r[22:0]};
  endfunction

  logic [31:0] rom [QUARTER];

  for (genvar n = 0; n < QUARTER; n++) begin : g_rom
    localparam logic [31:0] ENTRY =
      real_to_single(sin_taylor($itor(n) * PI / $itor(2 * QUARTER)));
    assign rom[n] = ENTRY;
  end

  state_t           state;
  logic             clk_en_q;
  logic [A+1:0]     phase;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       quad;
  logic [A-1:0]     idx;
  logic [A-1:0]     mirror;
  logic [31:0]      lut_val;
  logic             tmo_hit;

  assign quad    = phase[A+1:A];
  assign idx     = phase[A-1:0];
  assign mirror  = ~idx + 1'b1;
  assign tmo_hit = (tmo_cnt == CNT_W'(FP_TIMEOUT - 1));

  // i == 0 in quadrants 1..3 lands on exact axis values the ROM does not hold.
  always_comb begin
    lut_val = '0;
    case (quad)
      2'd0:    lut_val = rom[idx];
      2'd1:    lut_val = (idx == '0) ? F_ONE : rom[mirror];
      2'd2:    lut_val = (idx == '0) ? 32'h0 : {1'b1, rom[idx][30:0]};
      default: lut_val = (idx == '0) ? F_NONE : {1'b1, rom[mirror][30:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      clk_en_q         <= 1'b0;
      phase            <= '0;
      tmo_cnt          <= '0;
      bus.sinus_done   <= 1'b0;
      bus.sinus_result <= '0;
      bus.sin_error    <= 1'b0;
      bus.fp_clk_en    <= 1'b0;
      bus.fp_dataa     <= '0;
      bus.fp_datab     <= '0;
      bus.fp_operation <= '0;
    end else begin
      clk_en_q       <= bus.sinus_clk_en;
      bus.fp_clk_en  <= 1'b0;
      bus.sinus_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.sinus_clk_en && !clk_en_q) begin
            bus.fp_dataa     <= bus.sinus_angle;
            bus.fp_datab     <= K_SCALE;
            bus.fp_operation <= OP_FMULS;
            bus.fp_clk_en    <= 1'b1;
            bus.sin_error    <= 1'b0;
            tmo_cnt          <= '0;
            state            <= S_SCALE;
          end
        end
        S_SCALE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.fp_done) begin
            bus.fp_dataa  <= bus.fp_result;
            bus.fp_clk_en <= 1'b1;
            tmo_cnt       <= '0;
`ifdef SINE_ROUND_EN
            bus.fp_datab     <= F_HALF;
            bus.fp_operation <= OP_FADDS;
            state            <= S_ROUND;
`else
            bus.fp_datab     <= bus.fp_result;
            bus.fp_operation <= OP_FIXSI;
            state            <= S_TO_INT;
`endif
          end else if (tmo_hit) begin
            bus.sinus_result <= '0;
            bus.sin_error    <= 1'b1;
            bus.sinus_done   <= 1'b1;
            state            <= S_DONE;
          end
        end
`ifdef SINE_ROUND_EN
        S_ROUND: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.fp_done) begin
            bus.fp_dataa     <= bus.fp_result;
            bus.fp_datab     <= bus.fp_result;
            bus.fp_operation <= OP_FIXSI;
            bus.fp_clk_en    <= 1'b1;
            tmo_cnt          <= '0;
            state            <= S_TO_INT;
          end else if (tmo_hit) begin
            bus.sinus_result <= '0;
            bus.sin_error    <= 1'b1;
            bus.sinus_done   <= 1'b1;
            state            <= S_DONE;
          end
        end
`endif
        S_TO_INT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.fp_done) begin
            phase <= bus.fp_result[A+1:0];
            state <= S_LOOKUP;
          end else if (tmo_hit) begin
            bus.sinus_result <= '0;
            bus.sin_error    <= 1'b1;
            bus.sinus_done   <= 1'b1;
            state            <= S_DONE;
          end
        end
        S_LOOKUP: begin
          bus.sinus_result <= lut_val;
          bus.sinus_done   <= 1'b1;
          state            <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_lut_unit.sv
// Scoreboarded bench for sine_lut_unit with a scripted 3-cycle fp-unit stub.
// Build with SINE_ROUND_EN defined to exercise the rounding path.
module tb_sine_lut_unit;

  localparam int A          = 8;
  localparam int FP_TIMEOUT = 64;
`ifdef SINE_ROUND_EN
  localparam int N_OPS = 3;
`else
  localparam int N_OPS = 2;
`endif

  logic clk;
  logic rst;

  sine_lut_unit_if sif();

  sine_lut_unit #(.LUT_ADDR_WIDTH(A), .FP_TIMEOUT(FP_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] stub_q[$];
  bit          stub_silent = 0;
  logic [2:0]  req_op[$];
  logic [31:0] req_a[$];
  logic [31:0] req_b[$];
  int          unstable = 0;
  int          done_cnt = 0;
  logic [31:0] exp_res_q[$];
  logic        exp_err_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // fp-unit stub: answers 3 cycles after each request, logs operands.
  initial begin : fp_stub
    int          countdown;
    logic [31:0] held_a;
    logic [31:0] held_b;
    logic [2:0]  held_op;
    countdown     = 0;
    held_a        = 0;
    held_b        = 0;
    held_op       = 0;
    sif.fp_done   = 0;
    sif.fp_result = 0;
    forever begin
      @(negedge clk);
      sif.fp_done = 1'b0;
      if (countdown > 0) begin
        if (sif.fp_dataa !== held_a || sif.fp_datab !== held_b || sif.fp_operation !== held_op)
          unstable++;
        countdown--;
        if (countdown == 0) begin
          sif.fp_done   = 1'b1;
          sif.fp_result = (stub_q.size() > 0) ? stub_q.pop_front() : 32'h0;
        end
      end
      if (sif.fp_clk_en === 1'b1) begin
        req_op.push_back(sif.fp_operation);
        req_a.push_back(sif.fp_dataa);
        req_b.push_back(sif.fp_datab);
        held_a  = sif.fp_dataa;
        held_b  = sif.fp_datab;
        held_op = sif.fp_operation;
        if (!stub_silent) countdown = 3;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sif.sinus_done === 1'b1) done_cnt++;
    end
  end

  // Reference ROM entry: double-precision sine rounded to single (nearest-even).
  function automatic logic [31:0] rom_ref(input int n);
    real         s;
    logic [63:0] d;
    logic [22:0] m;
    logic [28:0] rest;
    logic [23:0] mm;
    int          e;
    if (n == 0) return 32'h0;
    s    = $sin($itor(n) * 3.14159265358979323846 / 512.0);
    d    = $realtobits(s);
    e    = int'(d[62:52]) - 1023 + 127;
    m    = d[51:29];
    rest = d[28:0];
    if (rest[28] && ((|rest[27:0]) || m[0])) begin
      mm = {1'b0, m} + 24'd1;
      m  = mm[22:0];
      if (mm[23]) e = e + 1;
    end
    return {1'b0, e[7:0], m};
  endfunction

  task automatic script(input logic [31:0] scaled, input logic [31:0] phase);
    stub_q.push_back(scaled);
`ifdef SINE_ROUND_EN
    stub_q.push_back(scaled);
`endif
    stub_q.push_back(phase);
  endtask

  task automatic do_request(input logic [31:0] angle, input int budget, input bit drop,
                            output bit seen, output logic [31:0] res, output logic err,
                            output int lat);
    seen = 0;
    res  = 'x;
    err  = 'x;
    lat  = 0;
    sif.sinus_angle  = angle;
    sif.sinus_clk_en = 1'b1;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (sif.sinus_done === 1'b1) begin
        seen = 1;
        res  = sif.sinus_result;
        err  = sif.sin_error;
      end
    end
    if (drop) sif.sinus_clk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    sif.sinus_clk_en = 0;
    sif.sinus_angle  = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sif.sinus_done, sif.sin_error, sif.fp_clk_en} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got done/err/clk_en %b required 000",
               {sif.sinus_done, sif.sin_error, sif.fp_clk_en});
    end
    n_cmp++;
    if (sif.sinus_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_result: got %h required 00000000", sif.sinus_result);
    end
    n_cmp++;
    if ({sif.fp_dataa, sif.fp_datab, sif.fp_operation} !== 67'h0) begin
      n_err++;
      $display("FAIL reset_fp_bus: got a=%h b=%h op=%0d required zeros",
               sif.fp_dataa, sif.fp_datab, sif.fp_operation);
    end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_quarter_wave();
    bit seen; logic [31:0] res; logic err; int lat; int base; int d0; int u0;
    logic [31:0] e_res; logic e_err;
    base = req_op.size();
    d0   = done_cnt;
    u0   = unstable;
    script(32'h43800000, 32'd256);
    exp_res_q.push_back(32'h3F800000);
    exp_err_q.push_back(1'b0);
    do_request(32'h3FC90FDB, 60, 1, seen, res, err, lat);
    repeat (6) @(negedge clk);
    e_res = exp_res_q.pop_front();
    e_err = exp_err_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res) begin
      n_err++;
      $display("FAIL pi_half_result: got %h (done=%0d) required %h", res, seen, e_res);
    end
    n_cmp++;
    if (err !== e_err) begin
      n_err++;
      $display("FAIL pi_half_error: got %b required %b", err, e_err);
    end
    n_cmp++;
    if (req_op.size() - base != N_OPS) begin
      n_err++;
      $display("FAIL pi_half_req_count: got %0d required %0d", req_op.size() - base, N_OPS);
    end else begin
      n_cmp++;
      if (req_op[base] !== 3'd3 || req_b[base] !== 32'h4322F983 || req_a[base] !== 32'h3FC90FDB) begin
        n_err++;
        $display("FAIL pi_half_req1: got op=%0d a=%h b=%h required op=3 a=3fc90fdb b=4322f983",
                 req_op[base], req_a[base], req_b[base]);
      end
      n_cmp++;
      if (req_op[base+N_OPS-1] !== 3'd4) begin
        n_err++;
        $display("FAIL pi_half_req_fixsi: got op=%0d required 4", req_op[base+N_OPS-1]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL pi_half_done_pulses: got %0d required 1", done_cnt - d0);
    end
    n_cmp++;
    if (lat != 4 * N_OPS + 2) begin
      n_err++;
      $display("FAIL pi_half_latency: got %0d required %0d", lat, 4 * N_OPS + 2);
    end
    n_cmp++;
    if (unstable != u0) begin
      n_err++;
      $display("FAIL operand_stability: got %0d changes required 0", unstable - u0);
    end
  endtask

  task automatic test_quadrants();
    logic [31:0] ph [4];
    logic [31:0] ex [4];
    bit seen; logic [31:0] res; logic err; int lat; logic [31:0] e_res;
    ph = '{32'd0, 32'd512, 32'd768, 32'd1280};
    ex = '{32'h00000000, 32'h00000000, 32'hBF800000, 32'h3F800000};
    for (int k = 0; k < 4; k++) begin
      script(32'h40000000, ph[k]);
      exp_res_q.push_back(ex[k]);
      do_request(32'h3F000000, 60, 1, seen, res, err, lat);
      e_res = exp_res_q.pop_front();
      n_cmp++;
      if (!seen || res !== e_res) begin
        n_err++;
        $display("FAIL quadrant_phase_%0d: got %h (done=%0d) required %h", ph[k], res, seen, e_res);
      end
    end
  endtask

  task automatic test_rom();
    logic [31:0] ph [3];
    logic [31:0] ex [3];
    bit seen; logic [31:0] res; logic err; int lat; logic [31:0] e_res;
    ph = '{32'd100, 32'd924, 32'd300};
    ex = '{rom_ref(100), rom_ref(100) | 32'h80000000, rom_ref(212)};
    for (int k = 0; k < 3; k++) begin
      script(32'h42C80000, ph[k]);
      exp_res_q.push_back(ex[k]);
      do_request(32'h3E000000, 60, 1, seen, res, err, lat);
      e_res = exp_res_q.pop_front();
      n_cmp++;
      if (!seen || res !== e_res) begin
        n_err++;
        $display("FAIL rom_phase_%0d: got %h (done=%0d) required %h", ph[k], res, seen, e_res);
      end
    end
  endtask

`ifdef SINE_ROUND_EN
  task automatic test_round();
    bit seen; logic [31:0] res; logic err; int lat; int base; logic [31:0] e_res;
    base = req_op.size();
    stub_q.push_back(32'h437FFFFF);
    stub_q.push_back(32'h43803FFF);
    stub_q.push_back(32'd256);
    exp_res_q.push_back(32'h3F800000);
    do_request(32'h3FC90FDB, 60, 1, seen, res, err, lat);
    e_res = exp_res_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res) begin
      n_err++;
      $display("FAIL round_result: got %h (done=%0d) required %h", res, seen, e_res);
    end
    n_cmp++;
    if (req_op.size() - base != 3 || req_op[base+1] !== 3'd1 || req_b[base+1] !== 32'h3F000000
        || req_a[base+1] !== 32'h437FFFFF) begin
      n_err++;
      $display("FAIL round_fadds_req: got count=%0d required op=1 a=437fffff b=3f000000",
               req_op.size() - base);
    end
  endtask
`else
  task automatic test_truncate();
    bit seen; logic [31:0] res; logic err; int lat; int base; logic [31:0] e_res;
    base = req_op.size();
    stub_q.push_back(32'h437FFFFF);
    stub_q.push_back(32'd255);
    exp_res_q.push_back(rom_ref(255));
    do_request(32'h3FC90FDA, 60, 1, seen, res, err, lat);
    e_res = exp_res_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res) begin
      n_err++;
      $display("FAIL truncate_result: got %h (done=%0d) required %h", res, seen, e_res);
    end
    n_cmp++;
    if (req_op.size() - base != 2 || req_a[base+1] !== 32'h437FFFFF || req_b[base+1] !== 32'h437FFFFF) begin
      n_err++;
      $display("FAIL truncate_fixsi_operands: got count=%0d required 2 with a=b=437fffff",
               req_op.size() - base);
    end
  endtask
`endif

  task automatic test_held_level();
    bit seen; logic [31:0] res; logic err; int lat; int base; int d0; logic [31:0] e_res;
    base = req_op.size();
    d0   = done_cnt;
    script(32'h43800000, 32'd512);
    exp_res_q.push_back(32'h00000000);
    do_request(32'h3F800000, 60, 0, seen, res, err, lat);
    repeat (40) @(negedge clk);
    e_res = exp_res_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res) begin
      n_err++;
      $display("FAIL held_result: got %h (done=%0d) required %h", res, seen, e_res);
    end
    n_cmp++;
    if (req_op.size() - base != N_OPS || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL held_single_op: got %0d requests %0d dones required %0d and 1",
               req_op.size() - base, done_cnt - d0, N_OPS);
    end
    sif.sinus_clk_en = 0;
    repeat (2) @(negedge clk);
    script(32'h43800000, 32'd768);
    exp_res_q.push_back(32'hBF800000);
    do_request(32'h3F800000, 60, 1, seen, res, err, lat);
    e_res = exp_res_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res) begin
      n_err++;
      $display("FAIL held_second_op: got %h (done=%0d) required %h", res, seen, e_res);
    end
  endtask

  task automatic test_timeout();
    bit seen; logic [31:0] res; logic err; int lat; logic [31:0] e_res; logic e_err;
    stub_silent = 1;
    exp_res_q.push_back(32'h00000000);
    exp_err_q.push_back(1'b1);
    do_request(32'h3F800000, 120, 1, seen, res, err, lat);
    stub_silent = 0;
    e_res = exp_res_q.pop_front();
    e_err = exp_err_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res || err !== e_err) begin
      n_err++;
      $display("FAIL timeout_abort: got done=%0d res=%h err=%b required done=1 res=%h err=%b",
               seen, res, err, e_res, e_err);
    end
    n_cmp++;
    if (lat < FP_TIMEOUT || lat > FP_TIMEOUT + 2) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", lat, FP_TIMEOUT, FP_TIMEOUT + 2);
    end
    n_cmp++;
    if (sif.sin_error !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_error_held: got %b required 1", sif.sin_error);
    end
    script(32'h43800000, 32'd256);
    exp_res_q.push_back(32'h3F800000);
    exp_err_q.push_back(1'b0);
    do_request(32'h3F800000, 60, 1, seen, res, err, lat);
    e_res = exp_res_q.pop_front();
    e_err = exp_err_q.pop_front();
    n_cmp++;
    if (!seen || res !== e_res || err !== e_err) begin
      n_err++;
      $display("FAIL timeout_recover: got done=%0d res=%h err=%b required done=1 res=%h err=%b",
               seen, res, err, e_res, e_err);
    end
  endtask

  task automatic test_reset_mid();
    int base; int d0;
    script(32'h43800000, 32'd512);
    sif.sinus_angle  = 32'h3F800000;
    sif.sinus_clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1;
    sif.sinus_clk_en = 1'b0;
    #1;
    n_cmp++;
    if ({sif.sinus_done, sif.sin_error, sif.fp_clk_en} !== 3'b000 || sif.sinus_result !== 32'h0
        || sif.fp_dataa !== 32'h0 || sif.fp_operation !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got res=%h a=%h op=%0d required all zero",
               sif.sinus_result, sif.fp_dataa, sif.fp_operation);
    end
    base = req_op.size();
    d0   = done_cnt;
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || req_op.size() != base) begin
      n_err++;
      $display("FAIL reset_mid_stale_done: got %0d dones %0d requests required 0 and 0",
               done_cnt - d0, req_op.size() - base);
    end
    stub_q.delete();
  endtask

  initial begin
    rst = 1;
    sif.sinus_clk_en = 0;
    sif.sinus_angle  = 0;
    @(negedge clk);
    test_reset();
    test_quarter_wave();
    test_quadrants();
    test_rom();
`ifdef SINE_ROUND_EN
    test_round();
`else
    test_truncate();
`endif
    test_held_level();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sine_lut_unit.md
Name: sine_lut_unit

Overview:
- Responder end of the sinus interface used by the audio effects.
- Accepts an IEEE-754 single angle (radians) from an effect block and returns sin(angle) as an IEEE-754 single.
- Scales the angle and converts it to an integer phase by issuing requests on the shared fpUnit interface, using the same protocol the effects use.
- Resolves the phase through a quarter-wave ROM with quadrant symmetry, then raises a done pulse.

Parameters:
- LUT_ADDR_WIDTH, 8, log2 of quarter-wave ROM entries (A); full-cycle phase is 2^(A+2) steps.
- FP_TIMEOUT, 64, maximum cycles to wait for fp_done on one fp request before aborting.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sinus_clk_en  input  1  request; held high by the requester until it sees sinus_done
- sinus_angle  input  32  angle in radians, IEEE single; non-negative
- sinus_done  output  1  one-cycle pulse, result valid
- sinus_result  output  32  sin(angle), IEEE single; held until the next done
- sin_error  output  1  set on fp timeout; cleared on the next accepted request
- fp_dataa  output  32  fp operand A
- fp_datab  output  32  fp operand B
- fp_operation  output  3  fp opcode: 3 = fmuls, 4 = fixsi, 1 = fadds
- fp_clk_en  output  1  one-cycle pulse that issues an fp request
- fp_done  input  1  fp request complete
- fp_result  input  32  fp result, valid when fp_done = 1

Behaviour:
- Reset (async): state IDLE; sinus_done = 0; sinus_result = 0; sin_error = 0; fp_clk_en = 0; fp_dataa = 0; fp_datab = 0; fp_operation = 0. Reset mid-operation abandons the operation; a late fp_done is ignored in IDLE.
- Start condition: rising edge of sinus_clk_en while in IDLE. The previous value of sinus_clk_en is registered. A level held across an operation starts exactly one operation. Edges seen while busy are ignored. sinus_angle is latched on the start cycle.
- fp request protocol, per op:
  - Issue cycle: drive fp_dataa, fp_datab and fp_operation, and set fp_clk_en = 1 for exactly one cycle.
  - Operands stay stable until fp_done.
  - fp_result is captured on the cycle fp_done = 1.
  - The timeout counter resets at issue. If fp_done is still 0 after FP_TIMEOUT cycles: go to DONE, sinus_result = 0x00000000, sin_error = 1.
- States:
  - IDLE: waits for the start condition.
  - SCALE: fmuls(angle, K), where K = 2^(A+1)/pi. K is built from 2/pi = 0x3F22F983 with A added to the exponent field; A = 8 gives 0x4322F983.
  - ROUND: present only with the optional feature (see below).
  - TO_INT: fixsi(scaled, scaled) gives integer phase P.
  - LOOKUP: one cycle. q = P[A+1:A], i = P[A-1:0]. Higher bits of P are discarded; this is the wrap-around modulo 2*pi.
  - DONE: sinus_done = 1 for one cycle, then IDLE.
- ROM contents: entry n = sin(n*pi/2^(A+1)) as IEEE single, n = 0 .. 2^A-1. Initialised at elaboration.
- Quadrant mapping:
  - q0: rom[i]
  - q1: i == 0 ? 0x3F800000 : rom[2^A - i]
  - q2: i == 0 ? 0x00000000 : rom[i] with bit 31 set
  - q3: i == 0 ? 0xBF800000 : rom[2^A - i] with bit 31 set
  - Negative zero is never produced.
- Latency: from start edge to sinus_done = (sum of fp latencies) + 2 issue cycles + 1 LOOKUP cycle + 1.
- Valid range: angles whose scaled value fits in a signed 32-bit integer. Behaviour outside that range is whatever fixsi returns, then masked as above.

Optional Feature:
- Macro: SINE_ROUND_EN
- Defined: a ROUND state between SCALE and TO_INT issues fadds(scaled, 0x3F000000 = 0.5). fixsi therefore rounds to nearest, so pi/2 maps to index 2^A exactly. Adds one fp op of latency.
- Undefined: no ROUND state; fixsi truncates. An fp-unit result of 255.99998 yields P = 255.

Test Plan:
- All cases use a bench fp stub that answers 3 cycles after fp_clk_en with scripted results and checks operands; SINE_ROUND_EN is undefined unless stated.
- Angle 0x3FC90FDB, stub returns 0x43800000 then 256:
  - fp request 1 must be op 3 with B = 0x4322F983; request 2 must be op 4.
  - Expect sinus_result = 0x3F800000 with a single done pulse; sin_error = 0.
- Scripted phases 0, 512, 768, 1280 → results 0x00000000, 0x00000000, 0xBF800000, 0x3F800000. 1280 checks wrap-around.
- Phase 100 → result equals rom[100]. Phase 924 → rom[100] with bit 31 set (q3, i = 156, 256 - 156 = 100).
- sinus_clk_en held high across two operations' worth of cycles → exactly one pair of fp requests and one sinus_done. Drop sinus_clk_en, raise it again → second operation starts.
- Stub never asserts fp_done → sinus_done after 64 cycles with result 0x00000000 and sin_error = 1. Next request with a normal stub clears sin_error.
- Reset asserted while waiting on fp_done → outputs zeroed immediately. A stale fp_done after reset produces no sinus_done.
- With SINE_ROUND_EN: stub returns 255.99998, then an fadds result, then 256 → middle request must be op 1 with B = 0x3F000000; result 0x3F800000.
